// File: rtl/alu_result_sel_seq.sv
// Registered ALU / MOD result select: sequences the MOD unit via start/done and holds the
// chosen result behind valid/ready. Optional MOD timeout abort: ALU_RES_SEL_TIMEOUT_EN.
module alu_result_sel_seq #(
    parameter int              WIDTH   = 32,
    parameter int              OP_W    = 3,
    parameter logic [OP_W-1:0] MOD_OP  = 3'b111,
    parameter int              TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  Alu_Op,
    input  logic [WIDTH-1:0] other_res,
    output logic             mod_start,
    input  logic             mod_done,
    input  logic [WIDTH-1:0] mod_res,
    output logic [WIDTH-1:0] res,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_err,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE = 2'd0, MOD_WAIT = 2'd1, HOLD = 2'd2} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             mod_start_q, mod_start_d;
    logic             accept, is_mod;

    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("alu_result_sel_seq: TIMEOUT must be >= 2");
    end

`ifdef ALU_RES_SEL_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          res_err_q, res_err_d;
    assign res_err = res_err_q;
`else
    assign res_err = 1'b0;
`endif

    // A draining HOLD can take the next op in the same cycle, so results stream without a bubble.
    assign in_ready  = (state_q == IDLE) || ((state_q == HOLD) && res_ready);
    assign accept    = in_valid && in_ready;
    assign is_mod    = (Alu_Op == MOD_OP);
    assign res       = res_q;
    assign res_valid = (state_q == HOLD);
    assign busy      = (state_q == MOD_WAIT);
    assign mod_start = mod_start_q;

    always_comb begin
        state_d     = state_q;
        res_d       = res_q;
        mod_start_d = 1'b0;
`ifdef ALU_RES_SEL_TIMEOUT_EN
        cnt_d       = cnt_q;
        res_err_d   = res_err_q;
`endif
        case (state_q)
            MOD_WAIT: begin
                if (mod_done) begin
                    res_d   = mod_res;
                    state_d = HOLD;
`ifdef ALU_RES_SEL_TIMEOUT_EN
                    res_err_d = 1'b0;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    res_d     = '0;
                    res_err_d = 1'b1;
                    state_d   = HOLD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            IDLE, HOLD: begin
                if ((state_q == HOLD) && res_ready) state_d = IDLE;
                if (accept) begin
                    if (is_mod) begin
                        mod_start_d = 1'b1;
                        state_d     = MOD_WAIT;
`ifdef ALU_RES_SEL_TIMEOUT_EN
                        cnt_d       = '0;
`endif
                    end else begin
                        res_d   = other_res;
                        state_d = HOLD;
`ifdef ALU_RES_SEL_TIMEOUT_EN
                        res_err_d = 1'b0;
`endif
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            res_q       <= '0;
            mod_start_q <= 1'b0;
`ifdef ALU_RES_SEL_TIMEOUT_EN
            cnt_q       <= '0;
            res_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            res_q       <= res_d;
            mod_start_q <= mod_start_d;
`ifdef ALU_RES_SEL_TIMEOUT_EN
            cnt_q       <= cnt_d;
            res_err_q   <= res_err_d;
`endif
        end
    end
endmodule

// File: tb/tb_alu_result_sel_seq.sv
// Self-checking bench for alu_result_sel_seq: vector table, hand sequences, random vs model.
module tb_alu_result_sel_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  Alu_Op = '0;
    logic [31:0] other_res = '0;
    logic        mod_start;
    logic        mod_done = 1'b0;
    logic [31:0] mod_res = '0;
    logic [31:0] res;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic        res_err;
    logic        busy;

    int checks = 0;
    int errors = 0;

    alu_result_sel_seq #(.WIDTH(32), .OP_W(3), .MOD_OP(3'b111), .TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .Alu_Op(Alu_Op), .other_res(other_res), .mod_start(mod_start),
        .mod_done(mod_done), .mod_res(mod_res), .res(res), .res_valid(res_valid),
        .res_ready(res_ready), .res_err(res_err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        vld;
        logic [2:0]  op;
        logic [31:0] other;
        logic        rdy;
        logic        e_ir;
        logic        e_rv;
        logic [31:0] e_res;
    } vec_t;

    vec_t tbl[11];

    // transaction-level reference: is a MOD op in flight, is a result held, what result
    bit          m_wait, m_hold, m_start, exp_ir, acc, cd_on;
    logic [31:0] m_res;
    int          cd;

    initial begin
        tbl[0]  = '{1'b1, 3'b010, 32'h0000_1234, 1'b1, 1'b1, 1'b1, 32'h0000_1234};
        tbl[1]  = '{1'b0, 3'b010, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 32'h0000_1234};
        tbl[2]  = '{1'b1, 3'b000, 32'h0000_0001, 1'b1, 1'b1, 1'b1, 32'h0000_0001};
        tbl[3]  = '{1'b1, 3'b011, 32'h0000_0002, 1'b1, 1'b1, 1'b1, 32'h0000_0002};
        tbl[4]  = '{1'b1, 3'b110, 32'h0000_0003, 1'b1, 1'b1, 1'b1, 32'h0000_0003};
        tbl[5]  = '{1'b1, 3'b101, 32'h0000_0004, 1'b1, 1'b1, 1'b1, 32'h0000_0004};
        tbl[6]  = '{1'b1, 3'b001, 32'h0000_0005, 1'b0, 1'b0, 1'b1, 32'h0000_0004};
        tbl[7]  = '{1'b1, 3'b001, 32'h0000_0005, 1'b0, 1'b0, 1'b1, 32'h0000_0004};
        tbl[8]  = '{1'b1, 3'b001, 32'h0000_0005, 1'b0, 1'b0, 1'b1, 32'h0000_0004};
        tbl[9]  = '{1'b1, 3'b001, 32'h0000_0005, 1'b1, 1'b1, 1'b1, 32'h0000_0005};
        tbl[10] = '{1'b0, 3'b001, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 32'h0000_0005};

        // reset state
        #2;
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res", res, 32'd0);
        chk("rst_res_err", 32'(res_err), 32'd0);
        chk("rst_mod_start", 32'(mod_start), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        cyc();
        rst_n = 1'b1;

        // non-MOD, streaming and backpressure vectors
        for (int i = 0; i < 11; i++) begin
            in_valid = tbl[i].vld; Alu_Op = tbl[i].op; other_res = tbl[i].other;
            res_ready = tbl[i].rdy; mod_done = 1'b0;
            #1;
            chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].e_ir));
            cyc();
            chk($sformatf("vec%0d_res_valid", i), 32'(res_valid), 32'(tbl[i].e_rv));
            chk($sformatf("vec%0d_res", i), res, tbl[i].e_res);
            chk($sformatf("vec%0d_mod_start", i), 32'(mod_start), 32'd0);
            chk($sformatf("vec%0d_res_err", i), 32'(res_err), 32'd0);
        end

        // multi-cycle op, done 5 cycles after mod_start
        in_valid = 1'b1; Alu_Op = 3'b111; other_res = 32'h55; res_ready = 1'b1;
        #1;
        chk("mod_accept_ready", 32'(in_ready), 32'd1);
        cyc();
        chk("mod_start_pulse", 32'(mod_start), 32'd1);
        chk("mod_busy0", 32'(busy), 32'd1);
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1; Alu_Op = 3'b010; other_res = 32'h99; mod_done = 1'b0;
            #1;
            chk("mod_wait_in_ready", 32'(in_ready), 32'd0);
            cyc();
            chk("mod_wait_busy", 32'(busy), 32'd1);
            chk("mod_wait_start", 32'(mod_start), 32'd0);
            chk("mod_wait_valid", 32'(res_valid), 32'd0);
        end
        in_valid = 1'b0; mod_done = 1'b1; mod_res = 32'hDEAD_BEEF; res_ready = 1'b0;
        cyc();
        chk("mod_res_valid", 32'(res_valid), 32'd1);
        chk("mod_res", res, 32'hDEAD_BEEF);
        chk("mod_busy_end", 32'(busy), 32'd0);
        chk("mod_res_err", 32'(res_err), 32'd0);
        mod_done = 1'b1; mod_res = 32'h1111_1111;
        #1;
        chk("hold_in_ready", 32'(in_ready), 32'd0);
        cyc();
        chk("stray_done_valid", 32'(res_valid), 32'd1);
        chk("stray_done_res", res, 32'hDEAD_BEEF);
        mod_done = 1'b0;

        // multi-cycle op accepted from a draining HOLD, then reset while in flight
        in_valid = 1'b1; Alu_Op = 3'b111; res_ready = 1'b1;
        cyc();
        chk("hold_mod_start", 32'(mod_start), 32'd1);
        chk("hold_mod_busy", 32'(busy), 32'd1);
        chk("hold_mod_res_kept", res, 32'hDEAD_BEEF);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_mod_start", 32'(mod_start), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_res", res, 32'd0);
        chk("midrst_valid", 32'(res_valid), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        cyc();
        rst_n = 1'b1;
        cyc();
        chk("postrst_busy", 32'(busy), 32'd0);
        chk("postrst_valid", 32'(res_valid), 32'd0);

        // randomized traffic against the reference
        m_wait = 0; m_hold = 0; m_start = 0; m_res = '0; cd_on = 0; cd = 0;
        for (int c = 0; c < 2000; c++) begin
            chk("rnd_res_valid", 32'(res_valid), 32'(m_hold));
            chk("rnd_busy", 32'(busy), 32'(m_wait));
            chk("rnd_mod_start", 32'(mod_start), 32'(m_start));
            chk("rnd_res_err", 32'(res_err), 32'd0);
            if (m_hold) chk("rnd_res", res, m_res);
            if (c < 1990) begin
                in_valid  = ($urandom % 4) != 0;
                res_ready = ($urandom % 4) != 0;
            end else begin
                in_valid  = 1'b0;
                res_ready = 1'b1;
            end
            Alu_Op    = (($urandom % 3) == 0) ? 3'b111 : 3'($urandom % 7);
            other_res = $urandom;
            mod_res   = $urandom;
            mod_done  = 1'b0;
            if (m_start) begin
                cd = $urandom_range(0, 4);
                cd_on = 1;
            end
            if (cd_on) begin
                if (cd == 0) begin
                    mod_done = 1'b1;
                    cd_on = 0;
                end else cd--;
            end else if (!m_wait && ($urandom % 8) == 0) mod_done = 1'b1;
            exp_ir = !m_wait && (!m_hold || res_ready);
            #1;
            chk("rnd_in_ready", 32'(in_ready), 32'(exp_ir));
            acc = in_valid && exp_ir;
            m_start = 0;
            if (m_wait) begin
                if (mod_done) begin
                    m_res = mod_res; m_hold = 1; m_wait = 0;
                end
            end else begin
                if (m_hold && res_ready) m_hold = 0;
                if (acc) begin
                    if (Alu_Op == 3'b111) begin
                        m_wait = 1; m_start = 1; m_hold = 0;
                    end else begin
                        m_res = other_res; m_hold = 1;
                    end
                end
            end
            cyc();
        end
        mod_done = 1'b0;
        chk("rnd_drained_busy", 32'(busy), 32'd0);
        chk("rnd_drained_valid", 32'(res_valid), 32'd0);

`ifdef ALU_RES_SEL_TIMEOUT_EN
        // timeout abort after TIMEOUT (=8) MOD_WAIT cycles
        in_valid = 1'b1; Alu_Op = 3'b111; res_ready = 1'b1;
        cyc();
        in_valid = 1'b0;
        chk("to_busy0", 32'(busy), 32'd1);
        for (int k = 1; k < 8; k++) begin
            cyc();
            chk("to_wait_busy", 32'(busy), 32'd1);
            chk("to_wait_valid", 32'(res_valid), 32'd0);
        end
        res_ready = 1'b0;
        cyc();
        chk("to_valid", 32'(res_valid), 32'd1);
        chk("to_res", res, 32'd0);
        chk("to_err", 32'(res_err), 32'd1);
        chk("to_busy_end", 32'(busy), 32'd0);
        mod_done = 1'b1; mod_res = 32'h2222_2222;
        cyc();
        chk("to_stray_res", res, 32'd0);
        chk("to_stray_err", 32'(res_err), 32'd1);
        mod_done = 1'b0; res_ready = 1'b1;
        cyc();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
